// File: rtl/axil_crossbar_pkg.sv
// axil_crossbar_pkg: response codes and reply-path FSM states shared by the
// AXI4-lite crossbar response blocks.
package axil_crossbar_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DECERR} resp_state_t;
endpackage

// File: rtl/axil_resp_out_stage.sv
// axil_resp_out_stage: registered response output stage. Defining AXIL_CROSSBAR_RRESP_SKID_EN
// makes it a 2-entry skid buffer so in_ready no longer depends on out_ready.
module axil_resp_out_stage
    import axil_crossbar_pkg::*;
#(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
`ifdef AXIL_CROSSBAR_RRESP_SKID_EN
    logic [WIDTH-1:0] tmp_data;
    logic             tmp_valid;

    assign in_ready = !tmp_valid;

    // A load while main is stalled parks in tmp; the next drain promotes tmp into main.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            tmp_data  <= '0;
            tmp_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                tmp_data  <= in_data;
                tmp_valid <= 1'b1;
            end
        end else if (out_ready) begin
            if (tmp_valid) out_data <= tmp_data;
            out_valid <= tmp_valid;
            tmp_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: rtl/axil_crossbar_rresp.sv
// axil_crossbar_rresp: per-slave R return path; forwards the selected master's beat or
// synthesises DECERR. Output stage becomes a skid buffer with AXIL_CROSSBAR_RRESP_SKID_EN.
module axil_crossbar_rresp
    import axil_crossbar_pkg::*;
#(
    parameter int S          = 0,
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CL_M_COUNT = M_COUNT > 1 ? $clog2(M_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CL_M_COUNT-1:0]         cmd_select,
    input  logic                          cmd_decerr,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [M_COUNT*DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [M_COUNT*2-1:0]          m_axil_rresp,
    input  logic [M_COUNT-1:0]            m_axil_rvalid,
    output logic [M_COUNT-1:0]            m_axil_rready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready
);
    resp_state_t             state, state_next;
    logic [CL_M_COUNT-1:0]   sel_q;
    logic                    decerr_q;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [1:0]              sel_resp;
    logic                    sel_valid;
    logic                    ld_valid, ld_ready;
    logic [DATA_WIDTH+1:0]   ld_data;

    assign cmd_ready     = state == ST_IDLE;
    assign m_axil_rready = (state == ST_FWD && ld_ready) ? M_COUNT'(1) << sel_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            decerr_q <= 1'b0;
        end else begin
            state <= state_next;
            if (cmd_valid && cmd_ready) begin
                sel_q    <= cmd_select;
                decerr_q <= cmd_decerr;
            end
        end
    end

    // Only the latched master's lanes are muxed, so unselected rdata never reaches the output.
    always_comb begin
        sel_data  = '0;
        sel_resp  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (sel_q == CL_M_COUNT'(i)) begin
                sel_data  = m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_resp  = m_axil_rresp[i*2 +: 2];
                sel_valid = m_axil_rvalid[i];
            end
        end
    end

    always_comb begin
        ld_valid   = state == ST_DECERR || (state == ST_FWD && sel_valid);
        ld_data    = decerr_q ? {{DATA_WIDTH{1'b0}}, RESP_DECERR} : {sel_data, sel_resp};
        state_next = state == ST_IDLE ? (!cmd_valid ? ST_IDLE : cmd_decerr ? ST_DECERR : ST_FWD)
                   : (ld_valid && ld_ready) ? ST_IDLE : state;
    end

    axil_resp_out_stage #(.WIDTH(DATA_WIDTH + 2)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (ld_data),
        .in_valid (ld_valid),
        .in_ready (ld_ready),
        .out_data ({s_axil_rdata, s_axil_rresp}),
        .out_valid(s_axil_rvalid),
        .out_ready(s_axil_rready)
    );

    always_ff @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready && !cmd_decerr)
            assert (int'(cmd_select) < M_COUNT)
            else $error("axil_crossbar_rresp[%0d]: cmd_select %0d out of range", S, cmd_select);
    end
endmodule

// File: tb/tb_axil_crossbar_rresp.sv
// tb_axil_crossbar_rresp: randomized scoreboard bench; each master owns a pre-generated beat list and
// every accepted command claims the next beat of its master (or a DECERR beat).
module tb_axil_crossbar_rresp;
    import axil_crossbar_pkg::*;
    localparam int M = 4, DW = 32, NB = 48;
    typedef logic [DW+1:0] beat_t;

    logic            clk = 0, rst_n = 1;
    logic [1:0]      cmd_select;
    logic            cmd_decerr, cmd_valid, cmd_ready;
    logic [M*DW-1:0] m_axil_rdata = '0;
    logic [M*2-1:0]  m_axil_rresp = '0;
    logic [M-1:0]    m_axil_rvalid = '0, m_axil_rready;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            s_axil_rvalid, s_axil_rready;

    always #5 clk = ~clk;

    axil_crossbar_rresp #(.S(0), .M_COUNT(M), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_select(cmd_select), .cmd_decerr(cmd_decerr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
    );

    beat_t        mb [M][$];
    int           ptr_drv [M], ptr_exp [M];
    beat_t        exp_q [$];
    int           tests = 0, fails = 0;
    int           mval_pct = 100, srdy_pct = 100;
    logic [M-1:0] allow_mask = '0, mhs = '0;
    bit           tput_on = 0, chs = 0, last_srv = 0;
    int           tput_last = -1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // AXI rule: a presented beat stays put until its handshake.
    task automatic drive_masters();
        beat_t b;
        for (int i = 0; i < M; i++) begin
            if (m_axil_rvalid[i] && !mhs[i]) continue;
            if (ptr_drv[i] < NB && $urandom_range(0, 99) < mval_pct) begin
                b = mb[i][ptr_drv[i]];
                m_axil_rvalid[i] = 1'b1;
                m_axil_rdata[i*DW +: DW] = b[DW+1:2];
                m_axil_rresp[i*2 +: 2] = b[1:0];
            end else begin
                m_axil_rvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mhs = m_axil_rvalid & m_axil_rready;
        chs = cmd_valid && cmd_ready;
        last_srv = s_axil_rvalid;
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++) if (mhs[i]) ptr_drv[i]++;
        drive_masters();
        s_axil_rready = $urandom_range(0, 99) < srdy_pct;
    endtask

    task automatic issue(input int sel, input bit dec, input bit keep);
        int n = 0;
        cmd_select = 2'(sel);
        cmd_decerr = dec;
        cmd_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!chs && n < 200);
        chk(chs, "cmd_accept", 64'(chs), 1);
        if (chs) begin
            if (dec) exp_q.push_back({32'h0, RESP_DECERR});
            else exp_q.push_back(mb[sel][ptr_exp[sel]++]);
            allow_mask = dec ? '0 : 4'(1) << sel;
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic issue_rand(input bit keep);
        int avail[$];
        bit dec;
        for (int i = 0; i < M; i++) if (ptr_exp[i] < NB) avail.push_back(i);
        dec = avail.size() == 0 || $urandom_range(0, 4) == 0;
        issue(dec ? int'($urandom_range(0, M - 1)) : avail[$urandom_range(0, avail.size() - 1)], dec, keep);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            step();
            n++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    // Monitor: compares every slave-side beat against the scoreboard head.
    initial begin
        beat_t got, e, hold_v;
        bit held = 0;
        int cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                held = 0;
                continue;
            end
            got = {s_axil_rdata, s_axil_rresp};
            chk((m_axil_rready & ~allow_mask) == 0, "rready_unselected", m_axil_rready, allow_mask);
            if (held) chk(s_axil_rvalid && got == hold_v, "hold_stable", got, hold_v);
            if (s_axil_rvalid && s_axil_rready) begin
                chk(exp_q.size() > 0, "beat_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(got == e, "r_beat", got, e);
                end
                if (tput_on) begin
                    if (tput_last >= 0) chk(cyc - tput_last == 2, "throughput_gap", cyc - tput_last, 2);
                    tput_last = cyc;
                end
            end
            held = s_axil_rvalid && !s_axil_rready;
            hold_v = got;
        end
    end

    initial begin
        int a, b;
        for (int i = 0; i < M; i++)
            for (int k = 0; k < NB; k++) mb[i].push_back({$urandom(), 2'($urandom())});
        mb[2][0] = {32'hDEADBEEF, 2'b00};
        mb[3][0] = {32'h00003333, 2'b00};
        mb[1][0] = {32'h00001111, 2'b00};
        cmd_valid = 0;
        cmd_select = 0;
        cmd_decerr = 0;
        s_axil_rready = 1;
        drive_masters();
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk(s_axil_rvalid == 0, "reset_rvalid", s_axil_rvalid, 0);
        chk({s_axil_rdata, s_axil_rresp} == 0, "reset_rdata", {s_axil_rdata, s_axil_rresp}, 0);
        chk(m_axil_rready == 0, "reset_mready", m_axil_rready, 0);
        chk(cmd_ready == 1, "reset_cmd_ready", cmd_ready, 1);
        rst_n = 1;
        step();
        step();

        // forward from master 2, then DECERR, each with the two-cycle latency
        issue(2, 0, 0);
        step();
        chk(!last_srv, "lat_fwd_cycle", last_srv, 0);
        step();
        chk(last_srv, "lat_rvalid", last_srv, 1);
        issue(0, 1, 0);
        step();
        chk(!last_srv, "lat_decerr_cycle", last_srv, 0);
        step();
        chk(last_srv, "lat_decerr_rvalid", last_srv, 1);

        // master 1 waits while master 3 is served, then is served itself
        issue(3, 0, 0);
        issue(1, 0, 0);
        drain();

        // slave stall: data held, second command accepted, FSM then blocks
        srdy_pct = 0;
        issue(2, 0, 0);
        repeat (3) step();
        issue(0, 0, 0);
        repeat (4) step();
        chk(cmd_ready == 0, "stall_cmd_blocked", cmd_ready, 0);
        chk(m_axil_rready == 0, "stall_mready", m_axil_rready, 0);
        srdy_pct = 100;
        drain();

        // back-to-back commands at full rate
        tput_last = -1;
        tput_on = 1;
        issue(0, 0, 1);
        issue(1, 0, 1);
        issue(2, 0, 1);
        issue(1, 1, 0);
        drain();
        tput_on = 0;

        // randomized traffic with master and slave backpressure
        mval_pct = 70;
        srdy_pct = 70;
        for (int n = 0; n < 150; n++) begin
            issue_rand(0);
            repeat ($urandom_range(0, 2)) step();
        end
        drain();

        // asynchronous reset with a stalled beat in the output stage and FSM in FWD
        mval_pct = 100;
        srdy_pct = 0;
        step();
        a = ptr_exp[0] < NB ? 0 : 1;
        b = ptr_exp[3] < NB ? 3 : 2;
        issue(a, 0, 0);
        repeat (3) step();
        issue(b, 0, 0);
        step();
        chk(s_axil_rvalid == 1, "pre_reset_rvalid", s_axil_rvalid, 1);
        chk(cmd_ready == 0, "pre_reset_busy", cmd_ready, 0);
        #2 rst_n = 0;
        #1;
        chk(s_axil_rvalid == 0, "async_rst_rvalid", s_axil_rvalid, 0);
        chk({s_axil_rdata, s_axil_rresp} == 0, "async_rst_rdata", {s_axil_rdata, s_axil_rresp}, 0);
        chk(m_axil_rready == 0, "async_rst_mready", m_axil_rready, 0);
        chk(cmd_ready == 1, "async_rst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        allow_mask = '0;
        for (int i = 0; i < M; i++) ptr_exp[i] = ptr_drv[i];
        step();
        step();
        rst_n = 1;
        chk(cmd_ready == 1, "post_rst_cmd_ready", cmd_ready, 1);
        srdy_pct = 100;
        repeat (4) issue_rand(0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
